// File: rtl/mac_acc.sv
// mac_acc: multiply-accumulate unit with a radix-2 shift-add multiplier.
// An accepted start runs OPSIZE multiply steps, then one accumulate cycle.
// The accumulate cycle is followed by a one-cycle valid strobe.
// Signed mode works on magnitudes, then applies the product sign at accumulate time.
module mac_acc #(
  parameter int OPSIZE  = 8,
  parameter int ACCSIZE = 24,
  parameter bit SAT     = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               clr,
  input  logic               sgn,
  input  logic [OPSIZE-1:0]  A,
  input  logic [OPSIZE-1:0]  B,
  output logic [ACCSIZE-1:0] ACC,
  output logic               ready,
  output logic               valid,
  output logic               ovf
);

  localparam int PW = 2 * OPSIZE;             // product magnitude width
  localparam int EW = ACCSIZE + 1;            // one guard bit for overflow detection
  localparam int CW = $clog2(OPSIZE + 1);

  typedef enum logic [1:0] {IDLE, MUL, ACCUM} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       mcand_q, mcand_d;      // multiplicand, shifted left each step
  logic [OPSIZE-1:0]   mplier_q, mplier_d;    // multiplier, shifted right each step
  logic [PW-1:0]       prod_q, prod_d;        // partial product magnitude
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                psgn_q, psgn_d;
  logic                clr_q, clr_d;
  logic                sgn_q, sgn_d;
  logic [ACCSIZE-1:0]  acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic                valid_q, valid_d;

  logic [OPSIZE-1:0]   a_mag, b_mag;
  logic [EW-1:0]       prod_ext, prod_s, base, sum;
  logic                ovf_now;
  logic [ACCSIZE-1:0]  acc_res;

  // The magnitude of the most negative operand still fits in OPSIZE unsigned bits.
  assign a_mag = (sgn && A[OPSIZE-1]) ? -A : A;
  assign b_mag = (sgn && B[OPSIZE-1]) ? -B : B;

  // Accumulate datapath: the signed product added to the old ACC (or to 0), one bit wider than ACC.
  always_comb begin
    prod_ext = {{(EW-PW){1'b0}}, prod_q};
    prod_s   = psgn_q ? -prod_ext : prod_ext;
    base     = clr_q ? '0 : {sgn_q & acc_q[ACCSIZE-1], acc_q};
    sum      = base + prod_s;
    ovf_now  = 1'b0;
    acc_res  = sum[ACCSIZE-1:0];
    if (sgn_q) begin
      if (sum[EW-1] != sum[EW-2]) begin
        ovf_now = 1'b1;
        if (SAT) acc_res = sum[EW-1] ? {1'b1, {(ACCSIZE-1){1'b0}}}
                                     : {1'b0, {(ACCSIZE-1){1'b1}}};
      end
    end else if (sum[EW-1]) begin
      ovf_now = 1'b1;
      if (SAT) acc_res = '1;
    end
  end

  // Next-state logic and datapath control for IDLE -> MUL x OPSIZE -> ACCUM.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    psgn_d   = psgn_q;
    clr_d    = clr_q;
    sgn_d    = sgn_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        mcand_d  = {{(PW-OPSIZE){1'b0}}, a_mag};
        mplier_d = b_mag;
        prod_d   = '0;
        cnt_d    = '0;
        psgn_d   = sgn & (A[OPSIZE-1] ^ B[OPSIZE-1]);
        clr_d    = clr;
        sgn_d    = sgn;
        state_d  = MUL;
      end
      MUL: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(OPSIZE - 1)) state_d = ACCUM;
      end
      ACCUM: begin
        acc_d   = acc_res;
        // A clearing op drops the sticky flag, but its own overflow still sets it.
        ovf_d   = (clr_q ? 1'b0 : ovf_q) | ovf_now;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; an asynchronous reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      psgn_q   <= 1'b0;
      clr_q    <= 1'b0;
      sgn_q    <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      psgn_q   <= psgn_d;
      clr_q    <= clr_d;
      sgn_q    <= sgn_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  assign ACC   = acc_q;
  assign ready = (state_q == IDLE);
  assign valid = valid_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_mac_acc.sv
// Scoreboard bench for mac_acc.
// Three instances share one stimulus stream: 24-bit saturating, 16-bit saturating, and 16-bit wrapping.
// Each accept pushes the reference result, and a monitor pops it when valid is due.
module tb_mac_acc;
  localparam int OPS = 8;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, clr = 1'b0, sgn = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [23:0] acc0;
  logic [15:0] acc1, acc2;
  logic rdy0, rdy1, rdy2, vld0, vld1, vld2, ovf0, ovf1, ovf2;

  mac_acc #(.OPSIZE(OPS), .ACCSIZE(24), .SAT(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .start(start),
    .clr(clr), .sgn(sgn), .A(a), .B(b), .ACC(acc0), .ready(rdy0), .valid(vld0), .ovf(ovf0));
  mac_acc #(.OPSIZE(OPS), .ACCSIZE(16), .SAT(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .start(start),
    .clr(clr), .sgn(sgn), .A(a), .B(b), .ACC(acc1), .ready(rdy1), .valid(vld1), .ovf(ovf1));
  mac_acc #(.OPSIZE(OPS), .ACCSIZE(16), .SAT(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .start(start),
    .clr(clr), .sgn(sgn), .A(a), .B(b), .ACC(acc2), .ready(rdy2), .valid(vld2), .ovf(ovf2));

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0, n_acc = 0;

  // Optional spec-constant checks that ride along with an op: gm selects the instance(s).
  logic [2:0] gm = '0;
  longint gva = 0, gvb = 0, gvc = 0;
  bit goa = 0, gob = 0, goc = 0;

  typedef struct {
    longint cyc;
    longint e0, e1, e2;
    bit o0, o1, o2;
    logic [2:0] gm;
    longint gva, gvb, gvc;
    bit goa, gob, goc;
  } exp_t;
  exp_t sq[$];
  exp_t me;

  // Reference model state: ACC as an unsigned bit pattern, plus the sticky flag.
  longint macc[3];
  bit movf[3];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int wid(input int i);
    return (i == 0) ? 24 : 16;
  endfunction

  function automatic void ref_op(input int i, input bit c, input bit s, input logic [7:0] x,
                                 input logic [7:0] y);
    longint m, av, bv, base, r, hi, lo;
    bit o;
    m  = longint'(1) << wid(i);
    av = s ? longint'($signed(x)) : longint'(x);
    bv = s ? longint'($signed(y)) : longint'(y);
    base = c ? 0 : ((s && macc[i] >= m / 2) ? macc[i] - m : macc[i]);
    r  = base + av * bv;
    hi = s ? m / 2 - 1 : m - 1;
    lo = s ? -(m / 2) : 0;
    o  = 0;
    if (r > hi) begin o = 1; if (i != 2) r = hi; end
    else if (r < lo) begin o = 1; if (i != 2) r = lo; end
    macc[i] = r & (m - 1);
    movf[i] = (c ? 1'b0 : movf[i]) | o;
  endfunction

  // Accept detector: just before each rising edge, a start seen with ready high is an accepted op.
  always begin
    @(negedge clk);
    #4;
    if (rst_n && start && rdy0) begin
      exp_t e;
      for (int i = 0; i < 3; i++) ref_op(i, clr, sgn, a, b);
      e.cyc = cyc + OPS + 2;
      e.e0 = macc[0]; e.e1 = macc[1]; e.e2 = macc[2];
      e.o0 = movf[0]; e.o1 = movf[1]; e.o2 = movf[2];
      e.gm = gm; e.gva = gva; e.gvb = gvb; e.gvc = gvc;
      e.goa = goa; e.gob = gob; e.goc = goc;
      sq.push_back(e);
      n_acc++;
    end
  end

  // Monitor: every cycle, valid must match whether a result is due; when due, compare it.
  bit due;
  always begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      while (sq.size() > 0 && sq[0].cyc < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL valid missing: got none expected result at cycle %0d", sq[0].cyc);
        void'(sq.pop_front());
      end
      due = (sq.size() > 0 && sq[0].cyc == cyc);
      chk("valid0", longint'(vld0), longint'(due));
      chk("valid1", longint'(vld1), longint'(due));
      chk("valid2", longint'(vld2), longint'(due));
      if (due) begin
        me = sq.pop_front();
        chk("ACC0", longint'(acc0), me.e0);
        chk("ovf0", longint'(ovf0), longint'(me.o0));
        chk("ACC1", longint'(acc1), me.e1);
        chk("ovf1", longint'(ovf1), longint'(me.o1));
        chk("ACC2", longint'(acc2), me.e2);
        chk("ovf2", longint'(ovf2), longint'(me.o2));
        chk("ready in valid cycle", longint'(rdy0), 1);
        if (me.gm[0]) begin
          chk("gold ACC0", longint'(acc0), me.gva & 64'hFFFFFF);
          chk("gold ovf0", longint'(ovf0), longint'(me.goa));
        end
        if (me.gm[1]) begin
          chk("gold ACC1", longint'(acc1), me.gvb & 64'hFFFF);
          chk("gold ovf1", longint'(ovf1), longint'(me.gob));
        end
        if (me.gm[2]) begin
          chk("gold ACC2", longint'(acc2), me.gvc & 64'hFFFF);
          chk("gold ovf2", longint'(ovf2), longint'(me.goc));
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!rdy0 && n < 40) begin @(negedge clk); n++; end
    if (!rdy0) chk("ready wait timeout", longint'(rdy0), 1);
  endtask

  // Issue one op at a negedge; returns at the following negedge with start dropped.
  task automatic op(input bit c, input bit s, input logic [7:0] x, input logic [7:0] y,
                    input logic [2:0] m = 3'b000,
                    input longint va = 0, input bit oa = 0,
                    input longint vb = 0, input bit ob = 0,
                    input longint vc = 0, input bit oc = 0);
    wait_ready();
    clr = c; sgn = s; a = x; b = y; start = 1'b1;
    gm = m; gva = va; goa = oa; gvb = vb; gob = ob; gvc = vc; goc = oc;
    @(negedge clk);
    start = 1'b0; gm = '0;
    clr = 1'($urandom); sgn = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ACC0"}, longint'(acc0), 0);
    chk({tag, " ACC1"}, longint'(acc1), 0);
    chk({tag, " ACC2"}, longint'(acc2), 0);
    chk({tag, " ready"}, longint'(rdy0 & rdy1 & rdy2), 1);
    chk({tag, " valid"}, longint'(vld0 | vld1 | vld2), 0);
    chk({tag, " ovf"}, longint'(ovf0 | ovf1 | ovf2), 0);
  endtask

  initial begin
    int lows, n0, nd;
    for (int i = 0; i < 3; i++) begin macc[i] = 0; movf[i] = 0; end
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic signed op, plus the length of the busy window.
    op(1, 1, 8'd48, 8'd110, 3'b001, 5280, 0);
    lows = 0;
    while (!rdy0 && lows < 30) begin lows++; @(negedge clk); end
    chk("ready low cycles", lows, 9);

    // Signed accumulation, each op issued in the previous op's valid cycle.
    op(0, 1, 8'd48, 8'(-110), 3'b001, 0, 0);
    op(0, 1, 8'(-48), 8'(-110), 3'b001, 5280, 0);
    op(0, 1, 8'(-1), 8'(-1), 3'b001, 5281, 0);
    op(0, 1, 8'(-128), 8'(-128), 3'b001, 21665, 0);

    // Unsigned mode.
    op(1, 0, 8'd255, 8'd255, 3'b001, 65025, 0);
    op(0, 0, 8'd255, 8'd255, 3'b001, 130050, 0);

    // 16-bit saturation (u1) and wrap (u2).
    op(1, 1, 8'd127, 8'd127, 3'b110, 0, 0, 16129, 0, 16129, 0);
    op(0, 1, 8'd127, 8'd127, 3'b110, 0, 0, 32258, 0, 32258, 0);
    op(0, 1, 8'd127, 8'd127, 3'b110, 0, 0, 32767, 1, -17149, 1);
    op(0, 1, 8'(-128), 8'd127, 3'b010, 0, 0, 16511, 1);
    op(1, 1, 8'd1, 8'd1, 3'b111, 1, 0, 1, 0, 1, 0);

    // Start held through a whole op with changing operands: exactly two accepts.
    wait_ready();
    n0 = n_acc;
    clr = 1'b1; sgn = 1'b1; a = 8'($urandom); b = 8'($urandom); start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); clr = 1'($urandom); sgn = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    chk("accepts while start held", n_acc - n0, 2);

    // Reset in the middle of the multiply phase.
    wait_ready();
    op(0, 1, 8'd3, 8'd5);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid-op reset");
    sq.delete();
    for (int i = 0; i < 3; i++) begin macc[i] = 0; movf[i] = 0; end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op(0, 1, 8'd3, 8'd4, 3'b111, 12, 0, 12, 0, 12, 0);

    // Randomized ops against the reference model.
    repeat (40) op(($urandom_range(0, 3) == 0), 1'($urandom), 8'($urandom), 8'($urandom));

    nd = 0;
    while (sq.size() > 0 && nd < 100) begin @(negedge clk); nd++; end
    chk("results outstanding at end", sq.size(), 0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
